parity_checker: RTL and testbench

Pop-side consumer for the parity-protected FIFO stream. Drains words over the `valid/data/grant` handshake and checks each word's parity against the configured mode and bit position. Strips the parity bit and forwards the payload through a 2-entry output buffer to the downstream consumer. Keeps a saturating parity-error counter and a sticky error flag for status readout.

---
 rtl/types_pkg.sv | 14 +
 rtl/parity_checker.sv | 166 ++++++++++++++++
 tb/tb_parity_checker.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/types_pkg.sv
// Shared enumerations for the parity-protected FIFO stream.
package types_pkg;

  typedef enum logic {
    ODD  = 1'b0,
    EVEN = 1'b1
  } parity_mode_e;

  typedef enum logic {
    MSB = 1'b0,
    LSB = 1'b1
  } parity_bit_e;

endpackage

// File: rtl/parity_checker.sv
// parity_checker: pop-side consumer of the parity-protected FIFO stream.
// Checks each accepted word's parity, strips the parity bit and forwards
// {payload, perr} through a 2-entry output buffer. Keeps a saturating
// error counter and a sticky error flag.
// Optional build macro PARITY_ERR_DROP_EN: bad words are counted but not
// forwarded, and out_perr_o is always 0.
module parity_checker
  import types_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH        = 8,
  parameter parity_mode_e PARITY_MODE       = ODD,
  parameter parity_bit_e  PARITY_BIT_CHOICE = MSB,
  parameter int unsigned  ERR_CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     valid_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  output logic                     grant_o,
  output logic                     out_valid_o,
  output logic [DATA_WIDTH-2:0]    out_data_o,
  output logic                     out_perr_o,
  input  logic                     out_grant_i,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o,
  output logic                     err_sticky_o,
  input  logic                     err_clear_i
);

  localparam int unsigned PW = DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  // True when the word's ones-count disagrees with the configured parity.
  function automatic logic parity_bad(input logic [DATA_WIDTH-1:0] word);
    logic odd_ones;
    odd_ones = ^word;
    return (PARITY_MODE == ODD) ? ~odd_ones : odd_ones;
  endfunction

  // Drops the parity bit from the configured end of the word.
  function automatic logic [PW-1:0] strip_parity(input logic [DATA_WIDTH-1:0] word);
    return (PARITY_BIT_CHOICE == MSB) ? word[DATA_WIDTH-2:0] : word[DATA_WIDTH-1:1];
  endfunction

  // ---- stage p0: incoming word, handshake decode ----
  logic          word_bad_p0;
  logic [PW-1:0] word_payload_p0;
  logic          accept_p0;
  logic          push_p0;
  logic          push_perr_p0;
  logic          pop_p0;

  assign word_bad_p0     = parity_bad(data_i);
  assign word_payload_p0 = strip_parity(data_i);
  assign accept_p0       = valid_i & grant_o;
  assign pop_p0          = out_valid_o & out_grant_i;

`ifdef PARITY_ERR_DROP_EN
  assign push_p0      = accept_p0 & ~word_bad_p0;
  assign push_perr_p0 = 1'b0;
`else
  assign push_p0      = accept_p0;
  assign push_perr_p0 = word_bad_p0;
`endif

  // ---- stage p1: output buffer and status registers ----
  buf_state_e    state_p1, state_nxt;
  logic [PW-1:0] head_data_p1, head_data_nxt;
  logic          head_perr_p1, head_perr_nxt;
  logic [PW-1:0] tail_data_p1, tail_data_nxt;
  logic          tail_perr_p1, tail_perr_nxt;
  logic [ERR_CNT_WIDTH-1:0] err_count_p1;
  logic          err_sticky_p1;

  // Buffer next state: head is what downstream sees, tail is the second slot.
  always_comb begin
    state_nxt     = state_p1;
    head_data_nxt = head_data_p1;
    head_perr_nxt = head_perr_p1;
    tail_data_nxt = tail_data_p1;
    tail_perr_nxt = tail_perr_p1;
    case (state_p1)
      EMPTY: begin
        if (push_p0) begin
          state_nxt     = ONE;
          head_data_nxt = word_payload_p0;
          head_perr_nxt = push_perr_p0;
        end
      end
      ONE: begin
        case ({push_p0, pop_p0})
          2'b10: begin
            state_nxt     = FULL;
            tail_data_nxt = word_payload_p0;
            tail_perr_nxt = push_perr_p0;
          end
          2'b01: state_nxt = EMPTY;
          2'b11: begin
            // Head leaves as the new word arrives; occupancy stays at one.
            head_data_nxt = word_payload_p0;
            head_perr_nxt = push_perr_p0;
          end
          default: state_nxt = ONE;
        endcase
      end
      FULL: begin
        // grant_o is low here, so only a pop can happen.
        if (pop_p0) begin
          state_nxt     = ONE;
          head_data_nxt = tail_data_p1;
          head_perr_nxt = tail_perr_p1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Buffer registers; grant is registered from the next occupancy so it never
  // depends combinationally on out_grant_i.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_p1     <= EMPTY;
      head_data_p1 <= '0;
      head_perr_p1 <= 1'b0;
      tail_data_p1 <= '0;
      tail_perr_p1 <= 1'b0;
      grant_o      <= 1'b0;
    end else begin
      state_p1     <= state_nxt;
      head_data_p1 <= head_data_nxt;
      head_perr_p1 <= head_perr_nxt;
      tail_data_p1 <= tail_data_nxt;
      tail_perr_p1 <= tail_perr_nxt;
      grant_o      <= (state_nxt != FULL);
    end
  end

  // Saturating error counter and sticky flag; a new bad word beats a clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_count_p1  <= '0;
      err_sticky_p1 <= 1'b0;
    end else if (accept_p0 && word_bad_p0) begin
      err_sticky_p1 <= 1'b1;
      if (err_clear_i) begin
        err_count_p1 <= ERR_CNT_WIDTH'(1);
      end else if (err_count_p1 != '1) begin
        err_count_p1 <= err_count_p1 + ERR_CNT_WIDTH'(1);
      end
    end else if (err_clear_i) begin
      err_count_p1  <= '0;
      err_sticky_p1 <= 1'b0;
    end
  end

  assign out_valid_o  = (state_p1 != EMPTY);
  assign out_data_o   = head_data_p1;
  assign out_perr_o   = head_perr_p1;
  assign err_count_o  = err_count_p1;
  assign err_sticky_o = err_sticky_p1;

endmodule

// File: tb/tb_parity_checker.sv
// Self-checking bench for parity_checker: directed table, hand-written
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_parity_checker;
  import types_pkg::*;

`ifdef PARITY_ERR_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       valid_i;
  logic [7:0] data_i;
  logic       out_grant_i;
  logic       err_clear_i;

  // Main instance: 8 bits, ODD, MSB, 8-bit counter
  logic       a_grant, a_ovalid, a_perr, a_sticky;
  logic [6:0] a_odata;
  logic [7:0] a_cnt;
  // Saturation instance: 2-bit counter
  logic       s_grant, s_ovalid, s_perr, s_sticky;
  logic [6:0] s_odata;
  logic [1:0] s_cnt;
  // Variant instance: EVEN, LSB
  logic       l_grant, l_ovalid, l_perr, l_sticky;
  logic [6:0] l_odata;
  logic [7:0] l_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  parity_checker #(.DATA_WIDTH(8), .PARITY_MODE(ODD), .PARITY_BIT_CHOICE(MSB), .ERR_CNT_WIDTH(8)) u_a (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .data_i(data_i), .grant_o(a_grant),
    .out_valid_o(a_ovalid), .out_data_o(a_odata), .out_perr_o(a_perr), .out_grant_i(out_grant_i),
    .err_count_o(a_cnt), .err_sticky_o(a_sticky), .err_clear_i(err_clear_i));

  parity_checker #(.DATA_WIDTH(8), .PARITY_MODE(ODD), .PARITY_BIT_CHOICE(MSB), .ERR_CNT_WIDTH(2)) u_s (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .data_i(data_i), .grant_o(s_grant),
    .out_valid_o(s_ovalid), .out_data_o(s_odata), .out_perr_o(s_perr), .out_grant_i(out_grant_i),
    .err_count_o(s_cnt), .err_sticky_o(s_sticky), .err_clear_i(err_clear_i));

  parity_checker #(.DATA_WIDTH(8), .PARITY_MODE(EVEN), .PARITY_BIT_CHOICE(LSB), .ERR_CNT_WIDTH(8)) u_l (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .data_i(data_i), .grant_o(l_grant),
    .out_valid_o(l_ovalid), .out_data_o(l_odata), .out_perr_o(l_perr), .out_grant_i(out_grant_i),
    .err_count_o(l_cnt), .err_sticky_o(l_sticky), .err_clear_i(err_clear_i));

  typedef struct {
    logic [7:0] data;
    logic [6:0] payload;
    logic       bad;
  } vec_t;

  typedef struct packed {
    logic [6:0] p;
    logic       e;
  } ent_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    valid_i     = 1'b0;
    data_i      = 8'h00;
    out_grant_i = 1'b0;
    err_clear_i = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  vec_t vecs[8];
  ent_t q[$];

  initial begin
    int   exp_cnt;
    bit   exp_v;
    bit   rst, acc, bad, pop, m_grant, m_sticky;
    int   m_cnt;

    // ---------------- reset then idle ----------------
    reset_n = 1'b0; valid_i = 1'b0; data_i = 8'h00; out_grant_i = 1'b0; err_clear_i = 1'b0;
    tick();
    tick();
    chk("rst_grant", a_grant, 0);
    chk("rst_ovalid", a_ovalid, 0);
    chk("rst_odata", a_odata, 0);
    chk("rst_perr", a_perr, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_sticky", a_sticky, 0);
    reset_n = 1'b1;
    tick();
    chk("rel_grant", a_grant, 1);
    chk("rel_ovalid", a_ovalid, 0);
    chk("rel_cnt", a_cnt, 0);

    // ---------------- table-driven single words ----------------
    vecs[0] = '{8'b1000_0011, 7'h03, 1'b0};
    vecs[1] = '{8'b0000_0011, 7'h03, 1'b1};
    vecs[2] = '{8'h00,        7'h00, 1'b1};
    vecs[3] = '{8'hFF,        7'h7F, 1'b1};
    vecs[4] = '{8'h7F,        7'h7F, 1'b0};
    vecs[5] = '{8'h80,        7'h00, 1'b0};
    vecs[6] = '{8'hA5,        7'h25, 1'b1};
    vecs[7] = '{8'h01,        7'h01, 1'b0};
    exp_cnt = 0;
    out_grant_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      valid_i = 1'b1;
      data_i  = vecs[i].data;
      tick();
      valid_i = 1'b0;
      exp_cnt += int'(vecs[i].bad);
      exp_v = !(DROP && vecs[i].bad);
      chk($sformatf("vec%0d_ovalid", i), a_ovalid, exp_v);
      if (exp_v) begin
        chk($sformatf("vec%0d_odata", i), a_odata, vecs[i].payload);
        chk($sformatf("vec%0d_perr", i), a_perr, vecs[i].bad);
      end
      chk($sformatf("vec%0d_cnt", i), a_cnt, exp_cnt);
      tick();
      chk($sformatf("vec%0d_drain", i), a_ovalid, 0);
    end
    chk("vec_sticky", a_sticky, 1);

    // ---------------- backpressure ----------------
    do_reset();
    out_grant_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'h80;
    tick();
    chk("bp_grant1", a_grant, 1);
    data_i = 8'h81;
    tick();
    valid_i = 1'b0;
    chk("bp_grant_full", a_grant, DROP);
    chk("bp_ovalid", a_ovalid, 1);
    chk("bp_head0", a_odata, 7'h00);
    chk("bp_perr0", a_perr, 0);
    chk("bp_cnt", a_cnt, 1);
    tick();
    chk("bp_hold_data", a_odata, 7'h00);
    chk("bp_hold_valid", a_ovalid, 1);
    chk("bp_hold_grant", a_grant, DROP);
    out_grant_i = 1'b1;
    tick();
    chk("bp_grant_back", a_grant, 1);
    chk("bp_ovalid2", a_ovalid, !DROP);
`ifndef PARITY_ERR_DROP_EN
    chk("bp_head1", a_odata, 7'h01);
    chk("bp_perr1", a_perr, 1);
`endif
    tick();
    chk("bp_empty", a_ovalid, 0);

    // ---------------- saturation and clear ----------------
    do_reset();
    out_grant_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'h03;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("sat_cnt%0d", k), s_cnt, sat(k, 3));
    end
    valid_i = 1'b0;
    chk("sat_sticky", s_sticky, 1);
    chk("sat_wide_cnt", a_cnt, 4);
    err_clear_i = 1'b1;
    tick();
    err_clear_i = 1'b0;
    chk("clr_cnt", s_cnt, 0);
    chk("clr_sticky", s_sticky, 0);
    chk("clr_wide_cnt", a_cnt, 0);
    err_clear_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'h03;
    tick();
    err_clear_i = 1'b0;
    valid_i = 1'b0;
    chk("clrbad_cnt", s_cnt, 1);
    chk("clrbad_sticky", s_sticky, 1);
    chk("clrbad_wide_cnt", a_cnt, 1);

    // ---------------- EVEN / LSB variant ----------------
    do_reset();
    out_grant_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'b0000_0110;
    tick();
    chk("lsb_ovalid", l_ovalid, 1);
    chk("lsb_odata", l_odata, 7'h03);
    chk("lsb_perr", l_perr, 0);
    chk("lsb_cnt0", l_cnt, 0);
    data_i = 8'b0000_0111;
    tick();
    valid_i = 1'b0;
    chk("lsb_bad_ovalid", l_ovalid, !DROP);
`ifndef PARITY_ERR_DROP_EN
    chk("lsb_bad_odata", l_odata, 7'h03);
    chk("lsb_bad_perr", l_perr, 1);
`endif
    chk("lsb_cnt1", l_cnt, 1);
    chk("lsb_sticky", l_sticky, 1);

    // ---------------- randomized run against reference model ----------------
    do_reset();
    q.delete();
    m_grant  = 1'b1;
    m_cnt    = 0;
    m_sticky = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      reset_n     = !rst;
      valid_i     = ($urandom_range(0, 3) != 0);
      data_i      = 8'($urandom);
      out_grant_i = ($urandom_range(0, 2) != 0);
      err_clear_i = ($urandom_range(0, 19) == 0);
      if (rst) begin
        q.delete();
        m_grant  = 1'b0;
        m_cnt    = 0;
        m_sticky = 1'b0;
      end else begin
        acc = valid_i && m_grant;
        bad = (($countones(data_i) % 2) == 0);
        pop = (q.size() > 0) && out_grant_i;
        if (pop) void'(q.pop_front());
        if (acc && !(DROP && bad)) q.push_back(ent_t'{7'(data_i % 128), bad && !DROP});
        if (acc && bad) begin
          m_cnt    = err_clear_i ? 1 : m_cnt + 1;
          m_sticky = 1'b1;
        end else if (err_clear_i) begin
          m_cnt    = 0;
          m_sticky = 1'b0;
        end
        m_grant = (q.size() < 2);
      end
      tick();
      chk("rnd_grant", a_grant, m_grant);
      chk("rnd_ovalid", a_ovalid, q.size() > 0);
      if (q.size() > 0) begin
        chk("rnd_odata", a_odata, q[0].p);
        chk("rnd_perr", a_perr, q[0].e);
      end
      chk("rnd_cnt", a_cnt, sat(m_cnt, 255));
      chk("rnd_sat_cnt", s_cnt, sat(m_cnt, 3));
      chk("rnd_sticky", a_sticky, m_sticky);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
